// File: rtl/sram_pixel_prefetch.sv
// Fetches framebuffer words from SRAM and unpacks each one MSB-first into the pixel FIFO.
// Optional macro PREFETCH_TESTPATTERN_EN adds a test_pattern input that replaces SRAM reads with generated words.
module sram_pixel_prefetch #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [20:0] FB_BASE    = 21'h000000,
    parameter int          FB_WORDS   = 19200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    output logic                  sram_req,
    output logic [20:0]           sram_addr,
    input  logic                  sram_ack,
    input  logic [31:0]           sram_rdata,
    output logic                  fifo_wr_en,
    output logic [7:0]            fifo_wr_data,
    input  logic                  fifo_full,
    input  logic [ADDR_WIDTH:0]   fifo_level
`ifdef PREFETCH_TESTPATTERN_EN
    ,
    input  logic                  test_pattern
`endif
);

    localparam int                DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEVEL_LIMIT = (ADDR_WIDTH + 1)'(DEPTH - 4);
    localparam logic [15:0]       LAST_COUNT  = 16'(FB_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_UNPACK = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] word_cnt_r, word_cnt_s;
    logic [1:0]  byte_idx_r, byte_idx_s;
    logic [31:0] word_r, word_s;
    logic        abort_r, abort_s;
    logic        sram_req_r, sram_req_s;
    logic        fifo_wr_en_r, fifo_wr_en_s;
    logic [7:0]  fifo_wr_data_r, fifo_wr_data_s;
    logic        test_pattern_s;
    logic        complete_s;
    logic [31:0] fetched_s;

`ifdef PREFETCH_TESTPATTERN_EN
    assign test_pattern_s = test_pattern;
`else
    assign test_pattern_s = 1'b0;
`endif

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    select_byte = word[31:24];
            2'd1:    select_byte = word[23:16];
            2'd2:    select_byte = word[15:8];
            default: select_byte = word[7:0];
        endcase
    endfunction

    function automatic logic [31:0] pattern_word(input logic [5:0] cnt);
        pattern_word = {cnt, 2'b00, cnt, 2'b01, cnt, 2'b10, cnt, 2'b11};
    endfunction

    assign sram_addr    = FB_BASE + {5'd0, word_cnt_r};
    assign sram_req     = sram_req_r;
    assign fifo_wr_en   = fifo_wr_en_r;
    assign fifo_wr_data = fifo_wr_data_r;

    // A generated word completes the fetch before any request is raised.
    assign complete_s = (test_pattern_s && !sram_req_r) || (sram_ack && sram_req_r);
    assign fetched_s  = (test_pattern_s && !sram_req_r) ? pattern_word(word_cnt_r[5:0]) : sram_rdata;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_s        = state_r;
        word_cnt_s     = word_cnt_r;
        byte_idx_s     = byte_idx_r;
        word_s         = word_r;
        abort_s        = abort_r;
        sram_req_s     = 1'b0;
        fifo_wr_en_s   = 1'b0;
        fifo_wr_data_s = fifo_wr_data_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    word_cnt_s = 16'd0;
                end else if (fifo_level <= LEVEL_LIMIT) begin
                    state_s    = ST_REQ;
                    sram_req_s = ~test_pattern_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                sram_req_s = 1'b1;
                if (complete_s) begin
                    sram_req_s = 1'b0;
                    abort_s    = 1'b0;
                    // A restart seen during the fetch throws the returned word away.
                    if (frame_start || abort_r) begin
                        word_cnt_s = 16'd0;
                        state_s    = ST_IDLE;
                    end else begin
                        word_s     = fetched_s;
                        byte_idx_s = 2'd0;
                        state_s    = ST_UNPACK;
                    end
                end else if (frame_start) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = abort_r;
                end
            end
            ST_UNPACK: begin
                if (frame_start) begin
                    word_cnt_s = 16'd0;
                    byte_idx_s = 2'd0;
                    state_s    = ST_IDLE;
                end else if (!fifo_full) begin
                    fifo_wr_en_s   = 1'b1;
                    fifo_wr_data_s = select_byte(word_r, byte_idx_r);
                    if (byte_idx_r == 2'd3) begin
                        byte_idx_s = 2'd0;
                        word_cnt_s = word_cnt_r + 16'd1;
                        state_s    = ((word_cnt_r + 16'd1) == LAST_COUNT) ? ST_DONE : ST_IDLE;
                    end else begin
                        byte_idx_s = byte_idx_r + 2'd1;
                    end
                end else begin
                    byte_idx_s = byte_idx_r;
                end
            end
            ST_DONE: begin
                if (frame_start) begin
                    word_cnt_s = 16'd0;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            word_cnt_r     <= 16'd0;
            byte_idx_r     <= 2'd0;
            word_r         <= 32'd0;
            abort_r        <= 1'b0;
            sram_req_r     <= 1'b0;
            fifo_wr_en_r   <= 1'b0;
            fifo_wr_data_r <= 8'd0;
        end else begin
            state_r        <= state_s;
            word_cnt_r     <= word_cnt_s;
            byte_idx_r     <= byte_idx_s;
            word_r         <= word_s;
            abort_r        <= abort_s;
            sram_req_r     <= sram_req_s;
            fifo_wr_en_r   <= fifo_wr_en_s;
            fifo_wr_data_r <= fifo_wr_data_s;
        end
    end

endmodule

// File: tb/tb_sram_pixel_prefetch.sv
// Randomized self-checking bench for sram_pixel_prefetch with an SRAM responder and a byte-stream reference model.
module tb_sram_pixel_prefetch;

    localparam int          AW    = 5;
    localparam logic [20:0] BASE  = 21'h1FFFFE;
    localparam int          WORDS = 4;

    logic        clk = 1'b0;
    logic        reset_n, frame_start, sram_req, sram_ack, fifo_wr_en, fifo_full;
    logic [20:0] sram_addr;
    logic [31:0] sram_rdata;
    logic [7:0]  fifo_wr_data;
    logic [AW:0] fifo_level;
`ifdef PREFETCH_TESTPATTERN_EN
    logic        test_pattern;
`endif

    sram_pixel_prefetch #(.ADDR_WIDTH(AW), .FB_BASE(BASE), .FB_WORDS(WORDS)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .sram_req(sram_req), .sram_addr(sram_addr), .sram_ack(sram_ack), .sram_rdata(sram_rdata),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .fifo_level(fifo_level)
`ifdef PREFETCH_TESTPATTERN_EN
        , .test_pattern(test_pattern)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          req_cycles = 0;
    int          full_viol = 0;
    int          addr_unstable = 0;
    int          lat_fixed = -1;
    logic [7:0]  wr_log[$];
    int          wr_cyc[$];
    logic [20:0] ack_addr[$];
    int          ack_cyc[$];
    logic [31:0] mem[4];
    logic        full_q = 1'b0;
    logic        req_prev = 1'b0;
    logic [20:0] addr_prev = 21'd0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        full_q <= fifo_full;
    end

    function automatic logic [31:0] mem_word(input logic [20:0] addr);
        logic [20:0] off;
        off = addr - BASE;
        if (off < 21'd4) return mem[off[1:0]];
        return 32'hBAD0_0000;
    endfunction

    // Reference model: frame bytes are the words at FB_BASE+i, most significant byte first.
    function automatic logic [7:0] exp_byte(input int idx);
        logic [31:0] w;
        w = mem[idx / 4];
        return w[8 * (3 - idx % 4) +: 8];
    endfunction

    // Output monitor: sampled on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (fifo_wr_en === 1'b1) begin
            wr_log.push_back(fifo_wr_data);
            wr_cyc.push_back(cyc);
            if (full_q) full_viol++;
        end
        if (sram_req === 1'b1) begin
            req_cycles++;
            if (req_prev && sram_addr !== addr_prev) addr_unstable++;
        end
        req_prev  = (sram_req === 1'b1);
        addr_prev = sram_addr;
    end

    // SRAM arbiter responder with random or fixed latency.
    initial begin
        int age;
        int lat;
        age = 0; lat = 0;
        sram_ack = 1'b0; sram_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (sram_ack) begin
                sram_ack = 1'b0;
            end else if (sram_req === 1'b1) begin
                if (age == 0) lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                if (age >= lat) begin
                    sram_ack   = 1'b1;
                    sram_rdata = mem_word(sram_addr);
                    ack_addr.push_back(sram_addr);
                    ack_cyc.push_back(cyc);
                    age = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [AW:0] level);
        reset_n = 1'b0; frame_start = 1'b0; fifo_full = 1'b0; fifo_level = level;
        lat_fixed = -1;
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        tick(); tick();
        wr_log.delete(); wr_cyc.delete(); ack_addr.delete(); ack_cyc.delete();
        req_cycles = 0; full_viol = 0; addr_unstable = 0;
        reset_n = 1'b1;
    endtask

    task automatic wait_writes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (wr_log.size() >= n) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic wait_acks(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ack_addr.size() >= n) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; frame_start = 1'b0; fifo_full = 1'b0; fifo_level = '0;
        tick(); tick();
        n_checks++; if (sram_req !== 1'b0) $display("FAIL reset_req: got %b want 0", sram_req); else n_pass++;
        n_checks++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); else n_pass++;
        n_checks++; if (fifo_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data); else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] want[4];
        want[0] = 8'hAA; want[1] = 8'hBB; want[2] = 8'hCC; want[3] = 8'hDD;
        do_reset('0);
        mem[0] = 32'hAABBCCDD;
        lat_fixed = 2;
        wait_acks(1, ok);
        n_checks++; if (!ok) $display("FAIL basic_ack_timeout: got none want 1 ack"); else n_pass++;
        if (ok) begin
            n_checks++; if (ack_addr[0] !== BASE) $display("FAIL basic_addr: got %h want %h", ack_addr[0], BASE); else n_pass++;
        end
        wait_writes(4, ok);
        n_checks++; if (!ok) $display("FAIL basic_wr_timeout: got %0d want 4 writes", wr_log.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (wr_log[i] !== want[i]) $display("FAIL basic_byte%0d: got %h want %h", i, wr_log[i], want[i]); else n_pass++;
            end
            n_checks++; if (wr_cyc[3] - wr_cyc[0] != 3) $display("FAIL basic_gapless: got span %0d want 3", wr_cyc[3] - wr_cyc[0]); else n_pass++;
        end
        n_checks++; if (addr_unstable != 0) $display("FAIL basic_addr_stable: got %0d changes want 0", addr_unstable); else n_pass++;
    endtask

    task automatic test_threshold();
        do_reset(6'($urandom_range(29, 32)));
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if (req_cycles != 0) $display("FAIL thresh_hold: got %0d req cycles want 0", req_cycles); else n_pass++;
        fifo_level = 6'd28;
        tick(); tick();
        n_checks++; if (req_cycles == 0) $display("FAIL thresh_28: got %0d req cycles want >0", req_cycles); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset('0);
        wait_writes(2, ok);
        n_checks++; if (!ok) $display("FAIL bp_wr2_timeout: got %0d want 2 writes", wr_log.size()); else n_pass++;
        fifo_full = 1'b1;
        tick(); tick(); tick();
        fifo_full = 1'b0;
        for (int i = 0; i < 600 && wr_log.size() < 16; i++) begin
            tick();
            fifo_full = ($urandom_range(0, 3) == 0);
        end
        fifo_full = 1'b0;
        wait_writes(16, ok);
        n_checks++; if (!ok) $display("FAIL bp_wr16_timeout: got %0d want 16 writes", wr_log.size()); else n_pass++;
        n_checks++; if (full_viol != 0) $display("FAIL bp_write_while_full: got %0d want 0", full_viol); else n_pass++;
        if (ok) begin
            n_checks++; if (wr_cyc[2] - wr_cyc[1] != 4) $display("FAIL bp_cc_delay: got %0d want 4", wr_cyc[2] - wr_cyc[1]); else n_pass++;
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (wr_log[i] !== exp_byte(i)) $display("FAIL bp_byte%0d: got %h want %h", i, wr_log[i], exp_byte(i)); else n_pass++;
            end
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        int rc;
        logic [20:0] ea;
        do_reset('0);
        wait_writes(16, ok);
        n_checks++; if (!ok) $display("FAIL frame_timeout: got %0d want 16 writes", wr_log.size()); else n_pass++;
        rc = req_cycles;
        for (int i = 0; i < 30; i++) tick();
        n_checks++; if (wr_log.size() != 16) $display("FAIL frame_write_count: got %0d want 16", wr_log.size()); else n_pass++;
        n_checks++; if (req_cycles != rc || ack_addr.size() != 4) $display("FAIL frame_done_idle: got %0d acks want 4", ack_addr.size()); else n_pass++;
        if (ok && ack_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                ea = BASE + 21'(i);
                n_checks++; if (ack_addr[i] !== ea) $display("FAIL frame_addr%0d: got %h want %h", i, ack_addr[i], ea); else n_pass++;
            end
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (wr_log[i] !== exp_byte(i)) $display("FAIL frame_byte%0d: got %h want %h", i, wr_log[i], exp_byte(i)); else n_pass++;
            end
        end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_acks(5, ok);
        n_checks++; if (!ok) $display("FAIL frame_restart_timeout: got %0d want 5 acks", ack_addr.size()); else n_pass++;
        if (ok) begin
            n_checks++; if (ack_addr[4] !== BASE) $display("FAIL frame_restart_addr: got %h want %h", ack_addr[4], BASE); else n_pass++;
        end
    endtask

    task automatic test_abort_req();
        bit ok;
        for (int mode = 0; mode < 2; mode++) begin
            do_reset('0);
            lat_fixed = 4;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if ((mode == 0 && sram_req === 1'b1) || (mode == 1 && sram_ack === 1'b1)) begin ok = 1'b1; break; end
                tick();
            end
            n_checks++; if (!ok) $display("FAIL abort_req%0d_timeout: got none want req/ack", mode); else n_pass++;
            if (mode == 0) tick();
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            wait_acks(2, ok);
            n_checks++; if (!ok) $display("FAIL abort_req%0d_ack_timeout: got %0d want 2 acks", mode, ack_addr.size()); else n_pass++;
            if (ok) begin
                n_checks++; if (ack_addr[1] !== BASE) $display("FAIL abort_req%0d_addr: got %h want %h", mode, ack_addr[1], BASE); else n_pass++;
            end
            wait_writes(4, ok);
            n_checks++; if (!ok) $display("FAIL abort_req%0d_wr_timeout: got %0d want 4", mode, wr_log.size()); else n_pass++;
            if (ok && ack_cyc.size() >= 2) begin
                n_checks++; if (wr_cyc[0] <= ack_cyc[1]) $display("FAIL abort_req%0d_discard: got write at %0d want after %0d", mode, wr_cyc[0], ack_cyc[1]); else n_pass++;
                for (int i = 0; i < 4; i++) begin
                    n_checks++; if (wr_log[i] !== exp_byte(i)) $display("FAIL abort_req%0d_byte%0d: got %h want %h", mode, i, wr_log[i], exp_byte(i)); else n_pass++;
                end
            end
            n_checks++; if (addr_unstable != 0) $display("FAIL abort_req%0d_addr_stable: got %0d want 0", mode, addr_unstable); else n_pass++;
        end
    endtask

    task automatic test_abort_unpack();
        bit ok;
        do_reset('0);
        wait_writes(2, ok);
        n_checks++; if (!ok) $display("FAIL abort_unp_timeout: got %0d want 2 writes", wr_log.size()); else n_pass++;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_writes(6, ok);
        n_checks++; if (!ok) $display("FAIL abort_unp_wr_timeout: got %0d want 6", wr_log.size()); else n_pass++;
        if (ok && ack_cyc.size() >= 2) begin
            n_checks++; if (ack_addr[1] !== BASE) $display("FAIL abort_unp_addr: got %h want %h", ack_addr[1], BASE); else n_pass++;
            n_checks++; if (wr_cyc[2] <= ack_cyc[1]) $display("FAIL abort_unp_discard: got write at %0d want after %0d", wr_cyc[2], ack_cyc[1]); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (wr_log[i + 2] !== exp_byte(i)) $display("FAIL abort_unp_byte%0d: got %h want %h", i, wr_log[i + 2], exp_byte(i)); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        do_reset('0);
        wait_writes(2, ok);
        n_checks++; if (!ok) $display("FAIL rstmid_timeout: got %0d want 2 writes", wr_log.size()); else n_pass++;
        reset_n = 1'b0; tick();
        n_checks++; if (fifo_wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b want 0", fifo_wr_en); else n_pass++;
        n_checks++; if (sram_req !== 1'b0) $display("FAIL rstmid_req: got %b want 0", sram_req); else n_pass++;
        n_checks++; if (fifo_wr_data !== 8'h00) $display("FAIL rstmid_wr_data: got %h want 00", fifo_wr_data); else n_pass++;
        n = ack_addr.size();
        reset_n = 1'b1;
        wait_acks(n + 1, ok);
        n_checks++; if (!ok) $display("FAIL rstmid_refetch_timeout: got %0d want %0d acks", ack_addr.size(), n + 1); else n_pass++;
        if (ok) begin
            n_checks++; if (ack_addr[n] !== BASE) $display("FAIL rstmid_addr: got %h want %h", ack_addr[n], BASE); else n_pass++;
        end
    endtask

`ifdef PREFETCH_TESTPATTERN_EN
    task automatic test_testpattern();
        bit ok;
        logic [7:0] want;
        test_pattern = 1'b1;
        do_reset('0);
        wait_writes(16, ok);
        n_checks++; if (!ok) $display("FAIL tp_timeout: got %0d want 16 writes", wr_log.size()); else n_pass++;
        n_checks++; if (req_cycles != 0) $display("FAIL tp_no_req: got %0d req cycles want 0", req_cycles); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                want = 8'(((i / 4) << 2) + (i % 4));
                n_checks++; if (wr_log[i] !== want) $display("FAIL tp_byte%0d: got %h want %h", i, wr_log[i], want); else n_pass++;
            end
        end
        test_pattern = 1'b0;
    endtask
`endif

    initial begin
`ifdef PREFETCH_TESTPATTERN_EN
        test_pattern = 1'b0;
`endif
        test_reset();
        test_basic();
        test_threshold();
        test_backpressure();
        test_full_frame();
        test_abort_req();
        test_abort_unpack();
        test_reset_mid();
`ifdef PREFETCH_TESTPATTERN_EN
        test_testpattern();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_pixel_prefetch.md
SRAM_PIXEL_PREFETCH -- requirements
Module: sram_pixel_prefetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, is the FIFO pointer width; FIFO depth = 2**ADDR_WIDTH.
REQ-002 Parameter FB_BASE, default 21'h000000, is the framebuffer start word address in SRAM.
REQ-003 Parameter FB_WORDS, default 19200, is the framebuffer size in 32-bit words (320x240 8-bit pixels).
REQ-004 Port clk, input, 1, is the 50MHz SRAM/arbiter-domain clock; the block has only this clock.
REQ-005 Port reset_n, input, 1, is the synchronous active-low reset.
REQ-006 Port frame_start, input, 1, is a one-cycle pulse, already synchronised to clk, that restarts the frame fetch.
REQ-007 Port sram_req, output, 1, is the read request to the SRAM arbiter.
REQ-008 Port sram_addr, output, 21, is the requested word address.
REQ-009 Port sram_ack, input, 1, is a one-cycle pulse marking sram_rdata valid in that cycle.
REQ-010 Port sram_rdata, input, 32, is the SRAM read word.
REQ-011 Port fifo_wr_en, output, 1, is the pixel FIFO write strobe.
REQ-012 Port fifo_wr_data, output, 8, is the pixel byte.
REQ-013 Port fifo_full, input, 1, is the FIFO full flag.
REQ-014 Port fifo_level, input, ADDR_WIDTH+1, is the FIFO fill level seen from the write side.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, UNPACK and DONE.
REQ-016 IDLE SHALL go to REQ when fifo_level <= DEPTH-4; otherwise it SHALL stay in IDLE.
REQ-017 In REQ, sram_req SHALL be 1 and sram_addr = FB_BASE + word_cnt, held stable until sram_ack.
REQ-018 On sram_ack, the block SHALL latch sram_rdata, drop sram_req the next cycle and enter UNPACK.
REQ-019 UNPACK SHALL write bytes [31:24], [23:16], [15:8], [7:0] in that order, one per cycle, with fifo_wr_en=1 and no gaps.
REQ-020 If fifo_full=1 in UNPACK, fifo_wr_en SHALL be 0 and the current byte SHALL be held until fifo_full=0.
REQ-021 After the 4th byte, word_cnt SHALL increment; at word_cnt == FB_WORDS the FSM SHALL enter DONE, otherwise IDLE.
REQ-022 DONE SHALL issue no requests and no writes until frame_start.
REQ-023 frame_start in IDLE, UNPACK or DONE SHALL clear word_cnt, discard unwritten bytes and enter IDLE the next cycle.
REQ-024 frame_start in REQ SHALL keep sram_req asserted until sram_ack, discard that word, clear word_cnt and enter IDLE.
REQ-025 frame_start coincident with sram_ack SHALL be treated as REQ-024, so the word is discarded.
REQ-026 word_cnt SHALL be 16 bits wide; sram_addr SHALL be the 21-bit sum of FB_BASE and word_cnt, with wrap-around modulo 2**21.
REQ-027 sram_req, fifo_wr_en and fifo_wr_data SHALL be registered outputs.

Reset
REQ-028 While reset_n=0 at a clk edge, state SHALL be IDLE, word_cnt 0, and sram_req, fifo_wr_en and fifo_wr_data all 0.
REQ-029 Reset asserted during REQ SHALL drop sram_req immediately; the arbiter SHALL be reset together with this block.
REQ-030 After reset, fetching SHALL start from FB_BASE without waiting for frame_start.

Configuration
REQ-031 Macro PREFETCH_TESTPATTERN_EN, when defined, SHALL add a 1-bit input test_pattern.
REQ-032 While test_pattern=1, REQ SHALL complete in 1 cycle with no sram_req.
REQ-033 The test-pattern word SHALL be {word_cnt[5:0],2'b00, word_cnt[5:0],2'b01, word_cnt[5:0],2'b10, word_cnt[5:0],2'b11}.
REQ-034 When PREFETCH_TESTPATTERN_EN is undefined, the test_pattern port SHALL be absent and behaviour SHALL be as REQ-015..030.

Verification
REQ-035 fifo_level=0 after reset, ack 3 cycles after req with rdata 32'hAABBCCDD -> sram_addr=FB_BASE, then wr_data AA,BB,CC,DD on 4 consecutive cycles.
REQ-036 fifo_level=29 held -> sram_req stays 0; level drops to 28 -> sram_req=1 within 2 cycles.
REQ-037 fifo_full=1 for 3 cycles after byte BB -> fifo_wr_en=0 for those cycles, then CC,DD written; nothing lost or duplicated.
REQ-038 FB_WORDS=4 run to completion -> exactly 16 writes, state DONE, no further req; frame_start -> next sram_addr=FB_BASE.
REQ-039 frame_start during REQ and after 2 bytes of UNPACK -> discarded bytes never written, next request at FB_BASE.
REQ-040 reset_n=0 mid-UNPACK -> all outputs 0 next cycle; with the macro on and test_pattern=1, the first bytes are 00,01,02,03 with no sram_req.
